// File: rtl/tag_match_seq.sv
// Sequential tag matcher: a small tag array searched one entry per cycle through
// a single shared comparator, with a valid/ready request and response handshake.
module tag_match_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_tag,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic             srch_req,
    input  logic [WIDTH-1:0] srch_key,
    output logic             srch_rdy,
    output logic             rsp_valid,
    input  logic             rsp_rdy,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tags [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] key_nxt;
    logic             hit_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             match_c;

    // The one shared comparator, always looking at the entry under the scan pointer.
    assign match_c = valid[ptr] & (tags[ptr] == key);

    // Tag array: writable in every state; invalidate wins over write on the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tags[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    tags[i] <= wr_tag;
                end
                if (inv_en && (inv_idx == IDX_W'(i))) begin
                    valid[i] <= 1'b0;
                end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                    valid[i] <= 1'b1;
                end
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        key_nxt   = key;
        hit_nxt   = rsp_hit;
        idx_nxt   = rsp_idx;
        unique case (state)
            IDLE: begin
                if (srch_req) begin
                    key_nxt   = srch_key;
                    ptr_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (match_c) begin
                    hit_nxt   = 1'b1;
                    idx_nxt   = ptr;
                    state_nxt = RESP;
                end else if (ptr == LAST_IDX) begin
                    hit_nxt   = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = RESP;
                end else begin
                    ptr_nxt = ptr + IDX_W'(1);
                end
            end
            RESP: begin
                if (rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, search registers and registered status outputs decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            key       <= '0;
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            srch_rdy  <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            key       <= key_nxt;
            rsp_hit   <= hit_nxt;
            rsp_idx   <= idx_nxt;
            srch_rdy  <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule
